residual_encoder: RTL and testbench

Rice residual encoder for the FLAC encode path: the write-side counterpart of the residual decoder. Accepts signed 16-bit residuals one at a time, zigzag-folds each, emits the Rice code (unary quotient, stop bit, k LSBs) MSB-first into 16-bit words, and writes each completed word to RAM at consecutive addresses. On flush it zero-pads and writes the final partial word, then reports the end position, so a decoder can be started on that stream.

---
 rtl/residual_pkg.sv | 24 ++
 rtl/residual_encoder_if.sv | 28 ++
 rtl/rice_bit_packer.sv | 99 +++++++++
 rtl/residual_encoder.sv | 117 +++++++++++
 tb/tb_residual_encoder.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/residual_pkg.sv
// Shared definitions for the Rice residual encoder/decoder pair: widths,
// FSM state encoding and the zigzag fold that maps signed residuals to unsigned codes.
package residual_pkg;
  localparam int WORD_W = 16;
  localparam int ADDR_W = 16;
  localparam int RICE_W = 4;
  localparam int FILL_W = 4;
  localparam int BIT_W  = 5;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_IDLE,
    ST_UNARY,
    ST_STOP,
    ST_BINARY,
    ST_FLUSH,
    ST_DONE
  } state_t;

  // Zigzag: 0,-1,1,-2,... -> 0,1,2,3,...
  function automatic logic [WORD_W-1:0] fold(input logic [WORD_W-1:0] s);
    return {s[WORD_W-2:0], 1'b0} ^ {WORD_W{s[WORD_W-1]}};
  endfunction
endpackage

// File: rtl/residual_encoder_if.sv
// Sample/flush handshake plus RAM write port of the Rice residual encoder.
interface residual_encoder_if;
  import residual_pkg::*;

  logic              iStart;
  logic [ADDR_W-1:0] iStartAddr;
  logic [RICE_W-1:0] iRiceParam;
  logic [WORD_W-1:0] iSample;
  logic              iValid;
  logic              oReady;
  logic              iFlush;
  logic [WORD_W-1:0] oData;
  logic [ADDR_W-1:0] oWriteAddr;
  logic              oWriteEnable;
  logic [ADDR_W-1:0] oEndAddr;
  logic [BIT_W-1:0]  oEndBit;
  logic              oDone;

  modport master (
    output iStart, iStartAddr, iRiceParam, iSample, iValid, iFlush,
    input  oReady, oData, oWriteAddr, oWriteEnable, oEndAddr, oEndBit, oDone
  );

  modport slave (
    input  iStart, iStartAddr, iRiceParam, iSample, iValid, iFlush,
    output oReady, oData, oWriteAddr, oWriteEnable, oEndAddr, oEndBit, oDone
  );
endinterface

// File: rtl/rice_bit_packer.sv
// Serial-to-word packer: bits enter MSB-first, full words are written at an
// auto-incrementing address, and flush pads the tail word and reports the end position.
module rice_bit_packer
  import residual_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic              bit_valid_i,
  input  logic              bit_i,
  input  logic              flush_i,
  output logic [WORD_W-1:0] data_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] end_addr_o,
  output logic [BIT_W-1:0]  end_bit_o
);
  logic [WORD_W-1:0] word_q, word_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] end_addr_q, end_addr_d;
  logic [BIT_W-1:0]  end_bit_q, end_bit_d;
  logic [WORD_W-1:0] shifted;
  logic [BIT_W-1:0]  pad_shift;

  always_comb begin
    word_d     = word_q;
    fill_d     = fill_q;
    addr_d     = addr_q;
    data_d     = data_q;
    waddr_d    = waddr_q;
    we_d       = 1'b0;
    end_addr_d = end_addr_q;
    end_bit_d  = end_bit_q;
    shifted    = {word_q[WORD_W-2:0], bit_i};
    pad_shift  = BIT_W'(WORD_W) - {1'b0, fill_q};

    if (clear_i) begin
      word_d = '0;
      fill_d = '0;
      addr_d = start_addr_i;
    end else if (flush_i) begin
      // End position is taken before padding, so it marks the first unused bit.
      end_addr_d = addr_q;
      end_bit_d  = BIT_W'(WORD_W - 1) - {1'b0, fill_q};
      if (fill_q != '0) begin
        data_d  = word_q << pad_shift;
        waddr_d = addr_q;
        we_d    = 1'b1;
      end
      word_d = '0;
      fill_d = '0;
    end else if (bit_valid_i) begin
      if (fill_q == FILL_W'(WORD_W - 1)) begin
        data_d  = shifted;
        waddr_d = addr_q;
        we_d    = 1'b1;
        addr_d  = addr_q + 1'b1;
        word_d  = '0;
        fill_d  = '0;
      end else begin
        word_d = shifted;
        fill_d = fill_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q     <= '0;
      fill_q     <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      waddr_q    <= '0;
      we_q       <= 1'b0;
      end_addr_q <= '0;
      end_bit_q  <= '0;
    end else begin
      word_q     <= word_d;
      fill_q     <= fill_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      waddr_q    <= waddr_d;
      we_q       <= we_d;
      end_addr_q <= end_addr_d;
      end_bit_q  <= end_bit_d;
    end
  end

  assign data_o     = data_q;
  assign waddr_o    = waddr_q;
  assign we_o       = we_q;
  assign end_addr_o = end_addr_q;
  assign end_bit_o  = end_bit_q;
endmodule

// File: rtl/residual_encoder.sv
// Rice residual encoder: folds each residual, walks unary/stop/binary phases one
// bit per cycle into the word packer, and finishes the stream on flush.
module residual_encoder
  import residual_pkg::*;
(
  input logic               iClock,
  input logic               iReset_n,
  residual_encoder_if.slave bus
);
  state_t            state_q, state_d;
  logic [WORD_W-1:0] u_q, u_d;
  logic [WORD_W-1:0] q_cnt_q, q_cnt_d;
  logic [RICE_W-1:0] k_q, k_d;
  logic [RICE_W-1:0] bit_idx_q, bit_idx_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic [WORD_W-1:0] folded;
  logic [WORD_W-1:0] quot;
  logic              bit_valid;
  logic              bit_val;
  logic              pk_flush;

  always_comb begin
    state_d   = state_q;
    u_d       = u_q;
    q_cnt_d   = q_cnt_q;
    k_d       = k_q;
    bit_idx_d = bit_idx_q;
    bit_valid = 1'b0;
    bit_val   = 1'b0;
    pk_flush  = 1'b0;
    folded    = fold(bus.iSample);
    quot      = folded >> k_q;

    if (bus.iStart) begin
      state_d = ST_IDLE;
      k_d     = bus.iRiceParam;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // A pending flush waits behind any sample offered in the same cycle.
          if (bus.iValid) begin
            u_d     = folded;
            q_cnt_d = quot;
            state_d = (quot != '0) ? ST_UNARY : ST_STOP;
          end else if (bus.iFlush) begin
            state_d = ST_FLUSH;
          end
        end
        ST_UNARY: begin
          bit_valid = 1'b1;
          q_cnt_d   = q_cnt_q - 1'b1;
          if (q_cnt_q == WORD_W'(1)) state_d = ST_STOP;
        end
        ST_STOP: begin
          bit_valid = 1'b1;
          bit_val   = 1'b1;
          bit_idx_d = k_q - 1'b1;
          state_d   = (k_q != '0) ? ST_BINARY : ST_IDLE;
        end
        ST_BINARY: begin
          bit_valid = 1'b1;
          bit_val   = u_q[bit_idx_q];
          bit_idx_d = bit_idx_q - 1'b1;
          if (bit_idx_q == '0) state_d = ST_IDLE;
        end
        ST_FLUSH: begin
          pk_flush = 1'b1;
          state_d  = ST_DONE;
        end
        ST_DONE:  state_d = ST_OFF;
        default:  state_d = ST_OFF;
      endcase
    end

    ready_d = (state_d == ST_IDLE);
    done_d  = (state_q == ST_DONE);
  end

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q   <= ST_OFF;
      u_q       <= '0;
      q_cnt_q   <= '0;
      k_q       <= '0;
      bit_idx_q <= '0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      u_q       <= u_d;
      q_cnt_q   <= q_cnt_d;
      k_q       <= k_d;
      bit_idx_q <= bit_idx_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
    end
  end

  rice_bit_packer u_packer (
    .clk          (iClock),
    .rst_n        (iReset_n),
    .clear_i      (bus.iStart),
    .start_addr_i (bus.iStartAddr),
    .bit_valid_i  (bit_valid),
    .bit_i        (bit_val),
    .flush_i      (pk_flush),
    .data_o       (bus.oData),
    .waddr_o      (bus.oWriteAddr),
    .we_o         (bus.oWriteEnable),
    .end_addr_o   (bus.oEndAddr),
    .end_bit_o    (bus.oEndBit)
  );

  assign bus.oReady = ready_q;
  assign bus.oDone  = done_q;
endmodule

// File: tb/tb_residual_encoder.sv
// Scoreboard bench for residual_encoder: expected RAM writes are queued as stimulus
// is driven and matched against writes observed on the bus.
module tb_residual_encoder;
  logic clk;
  logic rst_n;
  residual_encoder_if bus();

  residual_encoder dut (
    .iClock   (clk),
    .iReset_n (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_we_cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  logic [15:0] end_addr_s;
  logic [4:0]  end_bit_s;

  // Reference packer state for model-driven scenarios.
  logic [15:0] m_word;
  logic [15:0] m_addr;
  int          m_fill;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.oWriteEnable === 1'b1) begin
      obs_q.push_back({bus.oWriteAddr, bus.oData});
      last_we_cyc = cyc;
      $display("cycle %0d: write addr=%h data=%h", cyc, bus.oWriteAddr, bus.oData);
    end
    if (bus.oDone === 1'b1) begin
      done_cnt++;
      done_cyc   = cyc;
      end_addr_s = bus.oEndAddr;
      end_bit_s  = bus.oEndBit;
      $display("cycle %0d: done end_addr=%h end_bit=%0d", cyc, bus.oEndAddr, bus.oEndBit);
    end
  endtask

  task automatic start_stream(input logic [15:0] a, input logic [3:0] k);
    bus.iStart     = 1'b1;
    bus.iStartAddr = a;
    bus.iRiceParam = k;
    step();
    bus.iStart = 1'b0;
  endtask

  task automatic send(input logic [15:0] s);
    int n = 0;
    while (bus.oReady !== 1'b1 && n < 2000) begin
      step();
      n++;
    end
    if (bus.oReady !== 1'b1) begin
      errors++;
      $display("FAIL send_ready_timeout: oReady=%b required 1", bus.oReady);
    end
    bus.iSample = s;
    bus.iValid  = 1'b1;
    step();
    bus.iValid = 1'b0;
  endtask

  task automatic do_flush();
    done_cnt   = 0;
    bus.iFlush = 1'b1;
    for (int n = 0; n < 3000 && done_cnt == 0; n++) step();
    bus.iFlush = 1'b0;
    repeat (3) step();
  endtask

  task automatic model_init(input logic [15:0] a);
    m_word = '0;
    m_addr = a;
    m_fill = 0;
  endtask

  task automatic model_bit(input bit b);
    m_word = {m_word[14:0], b};
    m_fill++;
    if (m_fill == 16) begin
      exp_q.push_back({m_addr, m_word});
      m_addr = m_addr + 16'd1;
      m_fill = 0;
      m_word = '0;
    end
  endtask

  task automatic model_sample(input int s, input int k, output int u);
    u = (s >= 0) ? 2 * s : -2 * s - 1;
    for (int i = 0; i < (u >> k); i++) model_bit(1'b0);
    model_bit(1'b1);
    for (int i = k - 1; i >= 0; i--) model_bit(((u >> i) & 1) != 0);
  endtask

  task automatic model_flush(output logic [15:0] ea, output logic [4:0] eb);
    logic [15:0] padded;
    ea = m_addr;
    eb = 5'(15 - m_fill);
    if (m_fill > 0) begin
      padded = m_word << (16 - m_fill);
      exp_q.push_back({m_addr, padded});
    end
  endtask

  task automatic test_reset();
    bus.iStart = 0; bus.iStartAddr = 0; bus.iRiceParam = 0;
    bus.iSample = 0; bus.iValid = 0; bus.iFlush = 0;
    rst_n = 1'b0;
    repeat (3) step();
    checks++;
    if ({bus.oReady, bus.oWriteEnable, bus.oDone} !== 3'b000) begin
      errors++;
      $display("FAIL reset_strobes: got ready/we/done=%b required 000", {bus.oReady, bus.oWriteEnable, bus.oDone});
    end
    checks++;
    if ({bus.oData, bus.oWriteAddr, bus.oEndAddr, bus.oEndBit} !== 53'd0) begin
      errors++;
      $display("FAIL reset_values: got data=%h waddr=%h end_addr=%h end_bit=%0d required all 0",
               bus.oData, bus.oWriteAddr, bus.oEndAddr, bus.oEndBit);
    end
    rst_n = 1'b1;
    step();
    bus.iValid = 1'b1; bus.iFlush = 1'b1; bus.iSample = 16'h0000;
    repeat (4) step();
    bus.iValid = 1'b0; bus.iFlush = 1'b0;
    checks++;
    if (bus.oReady !== 1'b0 || obs_q.size() != 0 || done_cnt != 0) begin
      errors++;
      $display("FAIL off_ignores_inputs: got ready=%b writes=%0d done=%0d required 0 0 0",
               bus.oReady, obs_q.size(), done_cnt);
    end
  endtask

  task automatic test_k2_stream();
    logic [31:0] o, e;
    start_stream(16'h0100, 4'd2);
    obs_q.delete(); exp_q.delete();
    send(16'h0000); send(16'hFFFF); send(16'h0001); send(16'h0005);
    exp_q.push_back({16'h0100, 16'h9718});
    do_flush();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL k2 write_count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL k2 write: got addr=%h data=%h required addr=%h data=%h", o[31:16], o[15:0], e[31:16], e[15:0]);
      end
    end
    checks++;
    if (done_cnt != 1 || end_addr_s !== 16'h0100 || end_bit_s !== 5'd1) begin
      errors++;
      $display("FAIL k2 end: got done=%0d addr=%h bit=%0d required 1 0100 1", done_cnt, end_addr_s, end_bit_s);
    end
    checks++;
    if (done_cyc != last_we_cyc + 1) begin
      errors++;
      $display("FAIL k2 done_timing: got done cycle %0d required %0d", done_cyc, last_we_cyc + 1);
    end
  endtask

  task automatic test_k0_full_word();
    logic [31:0] o, e;
    start_stream(16'h0200, 4'd0);
    obs_q.delete(); exp_q.delete();
    repeat (16) send(16'h0000);
    repeat (2) step();
    checks++;
    if (obs_q.size() != 1) begin
      errors++;
      $display("FAIL k0 write_before_flush: got %0d writes required 1", obs_q.size());
    end
    exp_q.push_back({16'h0200, 16'hFFFF});
    do_flush();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL k0 write_count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL k0 write: got addr=%h data=%h required addr=%h data=%h", o[31:16], o[15:0], e[31:16], e[15:0]);
      end
    end
    checks++;
    if (done_cnt != 1 || end_addr_s !== 16'h0201 || end_bit_s !== 5'd15) begin
      errors++;
      $display("FAIL k0 end: got done=%0d addr=%h bit=%0d required 1 0201 15", done_cnt, end_addr_s, end_bit_s);
    end
  endtask

  task automatic test_k15_extreme();
    logic [31:0] o, e;
    int low = 0;
    start_stream(16'h0300, 4'd15);
    obs_q.delete(); exp_q.delete();
    bus.iSample = 16'h8000; bus.iValid = 1'b1;
    step();
    bus.iValid = 1'b0;
    while (bus.oReady !== 1'b1 && low < 200) begin step(); low++; end
    checks++;
    if (low != 17) begin
      errors++;
      $display("FAIL k15 busy_cycles: got %0d required 17", low);
    end
    exp_q.push_back({16'h0300, 16'h7FFF});
    exp_q.push_back({16'h0301, 16'h8000});
    do_flush();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL k15 write_count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL k15 write: got addr=%h data=%h required addr=%h data=%h", o[31:16], o[15:0], e[31:16], e[15:0]);
      end
    end
    checks++;
    if (done_cnt != 1 || end_addr_s !== 16'h0301 || end_bit_s !== 5'd14) begin
      errors++;
      $display("FAIL k15 end: got done=%0d addr=%h bit=%0d required 1 0301 14", done_cnt, end_addr_s, end_bit_s);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] o, e;
    int low = 0;
    start_stream(16'h0400, 4'd1);
    obs_q.delete(); exp_q.delete();
    bus.iSample = 16'h0003; bus.iValid = 1'b1;
    step();
    while (bus.oReady !== 1'b1 && low < 200) begin step(); low++; end
    bus.iValid = 1'b0;
    checks++;
    if (low != 5) begin
      errors++;
      $display("FAIL bp busy_cycles: got %0d required 5", low);
    end
    exp_q.push_back({16'h0400, 16'h1000});
    do_flush();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL bp write_count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL bp write: got addr=%h data=%h required addr=%h data=%h", o[31:16], o[15:0], e[31:16], e[15:0]);
      end
    end
    checks++;
    if (done_cnt != 1 || end_addr_s !== 16'h0400 || end_bit_s !== 5'd10) begin
      errors++;
      $display("FAIL bp end: got done=%0d addr=%h bit=%0d required 1 0400 10", done_cnt, end_addr_s, end_bit_s);
    end
  endtask

  task automatic test_addr_wrap();
    logic [31:0] o, e;
    start_stream(16'hFFFF, 4'd0);
    obs_q.delete(); exp_q.delete();
    send(16'h0003); send(16'hFFFE); send(16'h0000); send(16'h0007); send(16'h0002);
    exp_q.push_back({16'hFFFF, 16'h0230});
    exp_q.push_back({16'h0000, 16'h0021});
    do_flush();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL wrap write_count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL wrap write: got addr=%h data=%h required addr=%h data=%h", o[31:16], o[15:0], e[31:16], e[15:0]);
      end
    end
    checks++;
    if (done_cnt != 1 || end_addr_s !== 16'h0001 || end_bit_s !== 5'd15) begin
      errors++;
      $display("FAIL wrap end: got done=%0d addr=%h bit=%0d required 1 0001 15", done_cnt, end_addr_s, end_bit_s);
    end
  endtask

  task automatic test_restart();
    logic [31:0] o, e;
    start_stream(16'h0600, 4'd0);
    obs_q.delete(); exp_q.delete();
    send(16'h0001); send(16'h0000);
    start_stream(16'h0700, 4'd0);
    repeat (16) send(16'h0000);
    exp_q.push_back({16'h0700, 16'hFFFF});
    do_flush();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL restart write_count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL restart write: got addr=%h data=%h required addr=%h data=%h", o[31:16], o[15:0], e[31:16], e[15:0]);
      end
    end
    checks++;
    if (done_cnt != 1 || end_addr_s !== 16'h0701 || end_bit_s !== 5'd15) begin
      errors++;
      $display("FAIL restart end: got done=%0d addr=%h bit=%0d required 1 0701 15", done_cnt, end_addr_s, end_bit_s);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] o, e;
    logic [15:0] ea;
    logic [4:0]  eb;
    int k, s, u, low;
    k = int'($urandom_range(0, 4));
    start_stream(16'h1234, 4'(k));
    obs_q.delete(); exp_q.delete();
    model_init(16'h1234);
    for (int i = 0; i < 24; i++) begin
      s = int'($urandom_range(0, 40)) - 20;
      model_sample(s, k, u);
      bus.iSample = 16'(s); bus.iValid = 1'b1;
      step();
      low = 0;
      while (bus.oReady !== 1'b1 && low < 200) begin step(); low++; end
      checks++;
      if (low != (u >> k) + 1 + k) begin
        errors++;
        $display("FAIL b2b busy_cycles sample %0d (s=%0d k=%0d): got %0d required %0d", i, s, k, low, (u >> k) + 1 + k);
      end
    end
    bus.iValid = 1'b0;
    model_flush(ea, eb);
    do_flush();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL b2b write_count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL b2b write: got addr=%h data=%h required addr=%h data=%h", o[31:16], o[15:0], e[31:16], e[15:0]);
      end
    end
    checks++;
    if (done_cnt != 1 || end_addr_s !== ea || end_bit_s !== eb) begin
      errors++;
      $display("FAIL b2b end: got done=%0d addr=%h bit=%0d required 1 %h %0d", done_cnt, end_addr_s, end_bit_s, ea, eb);
    end
  endtask

  task automatic test_async_reset();
    start_stream(16'h0500, 4'd0);
    obs_q.delete(); exp_q.delete();
    send(16'd20);
    repeat (5) step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.oReady, bus.oWriteEnable, bus.oDone} !== 3'b000) begin
      errors++;
      $display("FAIL async_reset_strobes: got ready/we/done=%b required 000", {bus.oReady, bus.oWriteEnable, bus.oDone});
    end
    checks++;
    if ({bus.oData, bus.oWriteAddr, bus.oEndAddr, bus.oEndBit} !== 53'd0) begin
      errors++;
      $display("FAIL async_reset_values: got data=%h waddr=%h end_addr=%h end_bit=%0d required all 0",
               bus.oData, bus.oWriteAddr, bus.oEndAddr, bus.oEndBit);
    end
    repeat (4) step();
    rst_n = 1'b1;
    repeat (30) step();
    checks++;
    if (obs_q.size() != 0 || bus.oReady !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_after: got writes=%0d ready=%b required 0 0", obs_q.size(), bus.oReady);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_k2_stream();
    test_k0_full_word();
    test_k15_extreme();
    test_backpressure();
    test_addr_wrap();
    test_restart();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
